// File: rtl/fir_pkg.sv
// Shared definitions for the FIR upstream sequencer: opcodes, header layout,
// FSM state encoding and the common counter width.
package fir_pkg;

  // Header opcodes carried in the top two bits of a header byte
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STREAM = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  // Header field positions
  localparam int HDR_OP_MSB  = 7;
  localparam int HDR_OP_LSB  = 6;
  localparam int HDR_ARG_MSB = 5;
  localparam int HDR_ARG_LSB = 0;
  localparam int HDR_ARG_W   = HDR_ARG_MSB - HDR_ARG_LSB + 1;

  // One shared counter covers hold-off, sample, flush and gap counting;
  // 7 bits holds a full 64-sample STREAM length without wrapping.
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    COLLECT,
    BURST,
    STREAM,
    FLUSH,
    GAP
  } state_t;

endpackage

// File: rtl/fir_coef_buffer.sv
// Coefficient holding array: written in arrival order during COLLECT and
// read back in the same order during BURST. Each side has its own pointer
// that wraps after the last tap, so a completed load leaves both at zero.
module fir_coef_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             wr_last,
  output logic             rd_last
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;

  assign wr_last = (wr_ptr_reg == PW'(DEPTH - 1));
  assign rd_last = (rd_ptr_reg == PW'(DEPTH - 1));
  // Combinational read is fine here: the consumer registers x_n itself
  assign rd_data = mem_reg[rd_ptr_reg];

  // Write and read pointers, each wrapping after the last tap
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_last ? '0 : wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_last ? '0 : rd_ptr_reg + 1'b1;
    end
  end

  // Storage cells; contents survive reset, only the pointers restart
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr_reg == PW'(gi))) mem_reg[gi] <= wr_data;
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Upstream sequencer for the FIR stage. Decodes a byte-packet stream into
// coefficient bursts, sample streaming and zero flushes while enforcing the
// FIR's setup hold-off, gapless bursts and idle gap after every burst.
// state_reg always names the state whose outputs are currently visible; each
// edge computes the next state together with that state's registered outputs.
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter int X_N_SIZE     = 8,
  parameter int NBR_OF_TAPS  = 3,
  parameter int SETUP_CYCLES = 4,
  parameter int FLUSH_LEN    = 5,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_axis_fir_tvalid,
  output logic                s_set_coeffs,
  output logic                busy,
  output logic                cmd_done
);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    len_reg;
  logic                burst_last_reg;
  logic [X_N_SIZE-1:0] x_n_reg;
  logic                tvalid_reg;
  logic                set_coeffs_reg;
  logic                in_ready_reg;
  logic                cmd_done_reg;
  logic                busy_reg;

  logic                 accept;
  logic [1:0]           hdr_op;
  logic [HDR_ARG_W-1:0] hdr_arg;
  logic                 buf_clr;
  logic                 buf_wr_en;
  logic                 buf_rd_en;
  logic [X_N_SIZE-1:0]  buf_rd_data;
  logic                 buf_wr_last;
  logic                 buf_rd_last;
  logic [X_N_SIZE-1:0]  first_coef;

  assign accept  = in_valid && in_ready_reg;
  assign hdr_op  = in_data[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_arg = in_data[HDR_ARG_MSB:HDR_ARG_LSB];

  // With a single tap the byte being written is also the first one shown
  assign first_coef = (NBR_OF_TAPS == 1) ? in_data : buf_rd_data;

  assign in_ready          = in_ready_reg;
  assign x_n               = x_n_reg;
  assign s_axis_fir_tvalid = tvalid_reg;
  assign s_set_coeffs      = set_coeffs_reg;
  assign busy              = busy_reg;
  assign cmd_done          = cmd_done_reg;

  // Coefficient buffer pointer controls follow the FSM phase
  always_comb begin
    buf_clr   = 1'b0;
    buf_wr_en = 1'b0;
    buf_rd_en = 1'b0;
    case (state_reg)
      IDLE:    buf_clr = accept && (hdr_op == OP_LOAD);
      COLLECT: begin
        buf_wr_en = accept;
        buf_rd_en = accept && buf_wr_last;
      end
      BURST:   buf_rd_en = !burst_last_reg;
      default: ;
    endcase
  end

  fir_coef_buffer #(
    .WIDTH (X_N_SIZE),
    .DEPTH (NBR_OF_TAPS)
  ) u_coef_buffer (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr_en),
    .wr_data (in_data),
    .rd_en   (buf_rd_en),
    .rd_data (buf_rd_data),
    .wr_last (buf_wr_last),
    .rd_last (buf_rd_last)
  );

  // Sequencer FSM with counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= WAIT_INIT;
      cnt_reg        <= '0;
      len_reg        <= '0;
      burst_last_reg <= 1'b0;
      x_n_reg        <= '0;
      tvalid_reg     <= 1'b0;
      set_coeffs_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      cmd_done_reg   <= 1'b0;
      busy_reg       <= 1'b1;
    end else begin
      // Strobes and the done pulse are single-cycle unless re-asserted; x_n holds
      tvalid_reg     <= 1'b0;
      set_coeffs_reg <= 1'b0;
      cmd_done_reg   <= 1'b0;
      case (state_reg)
        WAIT_INIT: begin
          if (cnt_reg == CNT_W'(SETUP_CYCLES - 1)) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            case (hdr_op)
              OP_LOAD: begin
                state_reg <= COLLECT;
                busy_reg  <= 1'b1;
              end
              OP_STREAM: begin
                state_reg <= STREAM;
                busy_reg  <= 1'b1;
                len_reg   <= CNT_W'(hdr_arg) + CNT_W'(1);
                cnt_reg   <= '0;
              end
              OP_FLUSH: begin
                state_reg    <= FLUSH;
                busy_reg     <= 1'b1;
                in_ready_reg <= 1'b0;
                tvalid_reg   <= 1'b1;
                x_n_reg      <= '0;
                cnt_reg      <= CNT_W'(1);
              end
              default: cmd_done_reg <= 1'b1;
            endcase
          end
        end
        COLLECT: begin
          // Last coefficient byte starts the burst straight away with coef[0]
          if (accept && buf_wr_last) begin
            state_reg      <= BURST;
            in_ready_reg   <= 1'b0;
            set_coeffs_reg <= 1'b1;
            x_n_reg        <= first_coef;
            burst_last_reg <= (NBR_OF_TAPS == 1);
          end
        end
        BURST: begin
          if (burst_last_reg) begin
            state_reg    <= GAP;
            cnt_reg      <= '0;
            cmd_done_reg <= (GAP_CYCLES == 1);
          end else begin
            set_coeffs_reg <= 1'b1;
            x_n_reg        <= buf_rd_data;
            burst_last_reg <= buf_rd_last;
          end
        end
        STREAM: begin
          // in_ready drops with the last accept so its sample still issues
          if (cnt_reg == len_reg) begin
            state_reg    <= GAP;
            cnt_reg      <= '0;
            cmd_done_reg <= (GAP_CYCLES == 1);
          end else if (accept) begin
            x_n_reg      <= in_data;
            tvalid_reg   <= 1'b1;
            cnt_reg      <= cnt_reg + 1'b1;
            in_ready_reg <= ((cnt_reg + 1'b1) != len_reg);
          end
        end
        FLUSH: begin
          if (cnt_reg == CNT_W'(FLUSH_LEN)) begin
            state_reg    <= GAP;
            cnt_reg      <= '0;
            cmd_done_reg <= (GAP_CYCLES == 1);
          end else begin
            tvalid_reg <= 1'b1;
            x_n_reg    <= '0;
            cnt_reg    <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            cnt_reg      <= cnt_reg + 1'b1;
            cmd_done_reg <= ((cnt_reg + 1'b1) == CNT_W'(GAP_CYCLES - 1));
          end
        end
        default: state_reg <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: directed scenarios for reset, load, stream,
// flush and reset-abort, then a random command mix compared against an
// expected FIR event list built directly from the command semantics.
module tb_fir_stream_ctrl;

  localparam int XW    = 8;
  localparam int TAPS  = 3;
  localparam int SETUP = 4;
  localparam int FLEN  = 5;
  localparam int GAPC  = 1;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [XW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] x_n;
  logic          s_axis_fir_tvalid;
  logic          s_set_coeffs;
  logic          busy;
  logic          cmd_done;

  always #5 clk = ~clk;

  fir_stream_ctrl #(
    .X_N_SIZE     (XW),
    .NBR_OF_TAPS  (TAPS),
    .SETUP_CYCLES (SETUP),
    .FLUSH_LEN    (FLEN),
    .GAP_CYCLES   (GAPC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .x_n               (x_n),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_set_coeffs      (s_set_coeffs),
    .busy              (busy),
    .cmd_done          (cmd_done)
  );

  typedef struct {
    bit            coef;
    logic [XW-1:0] val;
    int            cyc;
    bit            rdy;
  } ev_t;

  ev_t ev_q[$];
  int  done_q[$];
  int  cyc_cnt = 0;
  int  both_cnt = 0;
  int  tests_run = 0;
  int  fails = 0;
  bit  timed_out = 1'b0;

  // Observer: logs every FIR strobe and done pulse, mid-cycle
  always @(negedge clk) begin
    ev_t e;
    cyc_cnt++;
    if (s_set_coeffs && s_axis_fir_tvalid) both_cnt++;
    if (s_set_coeffs || s_axis_fir_tvalid) begin
      e.coef = s_set_coeffs;
      e.val  = x_n;
      e.cyc  = cyc_cnt;
      e.rdy  = in_ready;
      ev_q.push_back(e);
    end
    if (cmd_done) done_q.push_back(cyc_cnt);
  end

  task automatic clear_logs();
    ev_q.delete();
    done_q.delete();
    both_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one byte after pre_gap idle cycles; acc_cyc is the observer
  // cycle right after the accepting edge
  task automatic send_byte(input logic [XW-1:0] b, input int pre_gap, output int acc_cyc);
    bit got;
    acc_cyc = -1;
    if (timed_out) return;
    wait_cycles(pre_gap);
    in_data  = b;
    in_valid = 1'b1;
    got      = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (got) begin
      acc_cyc = cyc_cnt + 1;
    end else begin
      tests_run++;
      fails++;
      timed_out = 1'b1;
      $display("FAIL handshake_timeout: byte %02h not accepted within %0d cycles", b, BUDGET);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 20) begin
      wait_cycles(1);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int acc;
    reset    = 1'b1;
    in_valid = 1'b0;
    wait_cycles(3);
    tests_run++; if (x_n !== 8'h00) begin fails++; $display("FAIL reset_x_n: got %02h expected 00", x_n); end
    tests_run++; if (s_axis_fir_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", s_axis_fir_tvalid); end
    tests_run++; if (s_set_coeffs !== 1'b0) begin fails++; $display("FAIL reset_set_coeffs: got %b expected 0", s_set_coeffs); end
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests_run++; if (cmd_done !== 1'b0) begin fails++; $display("FAIL reset_cmd_done: got %b expected 0", cmd_done); end
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
    reset = 1'b0;
    wait_ready(n);
    tests_run++; if (n !== SETUP) begin fails++; $display("FAIL holdoff_len: in_ready after %0d cycles expected %0d", n, SETUP); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    clear_logs();
    send_byte(8'h00, 0, acc);
    wait_cycles(4);
    tests_run++; if (done_q.size() !== 1) begin fails++; $display("FAIL nop_done_count: got %0d expected 1", done_q.size()); end
    else begin
      tests_run++; if (done_q[0] !== acc) begin fails++; $display("FAIL nop_done_cycle: got %0d expected %0d", done_q[0], acc); end
    end
    tests_run++; if (ev_q.size() !== 0) begin fails++; $display("FAIL nop_strobes: got %0d events expected 0", ev_q.size()); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL nop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_load();
    logic [XW-1:0] cb[TAPS] = '{8'h05, 8'hFF, 8'h02};
    int acc;
    clear_logs();
    send_byte(8'h40, 0, acc);
    for (int i = 0; i < TAPS; i++) send_byte(cb[i], 2, acc);
    wait_cycles(8);
    tests_run++; if (ev_q.size() !== TAPS) begin fails++; $display("FAIL load_count: got %0d strobes expected %0d", ev_q.size(), TAPS); end
    else begin
      for (int i = 0; i < TAPS; i++) begin
        tests_run++;
        if (ev_q[i].coef !== 1'b1 || ev_q[i].val !== cb[i] || ev_q[i].cyc !== ev_q[0].cyc + i || ev_q[i].rdy !== 1'b0) begin
          fails++;
          $display("FAIL load_coef[%0d]: got coef=%b x_n=%02h cyc=%0d rdy=%b expected coef=1 x_n=%02h cyc=%0d rdy=0",
                   i, ev_q[i].coef, ev_q[i].val, ev_q[i].cyc, ev_q[i].rdy, cb[i], ev_q[0].cyc + i);
        end
      end
      tests_run++; if (ev_q[0].cyc < acc) begin fails++; $display("FAIL load_order: burst at %0d before last byte at %0d", ev_q[0].cyc, acc); end
      tests_run++; if (done_q.size() !== 1 || done_q[0] !== ev_q[TAPS-1].cyc + GAPC) begin
        fails++;
        $display("FAIL load_done: got %0d pulses first at %0d expected 1 at %0d", done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, ev_q[TAPS-1].cyc + GAPC);
      end
    end
  endtask

  task automatic test_stream();
    logic [XW-1:0] sb[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    int sg[4] = '{0, 0, 2, 0};
    int acc[4];
    int hacc;
    clear_logs();
    send_byte(8'h83, 0, hacc);
    for (int i = 0; i < 4; i++) send_byte(sb[i], sg[i], acc[i]);
    wait_cycles(8);
    tests_run++; if (ev_q.size() !== 4) begin fails++; $display("FAIL stream_count: got %0d strobes expected 4", ev_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (ev_q[i].coef !== 1'b0 || ev_q[i].val !== sb[i] || ev_q[i].cyc !== acc[i]) begin
          fails++;
          $display("FAIL stream_sample[%0d]: got coef=%b x_n=%02h cyc=%0d expected coef=0 x_n=%02h cyc=%0d",
                   i, ev_q[i].coef, ev_q[i].val, ev_q[i].cyc, sb[i], acc[i]);
        end
      end
      tests_run++; if (done_q.size() !== 1 || done_q[0] !== acc[3] + GAPC) begin
        fails++;
        $display("FAIL stream_done: got %0d pulses first at %0d expected 1 at %0d", done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, acc[3] + GAPC);
      end
    end
  endtask

  task automatic test_flush();
    int acc;
    clear_logs();
    send_byte(8'hC0, 0, acc);
    wait_cycles(10);
    tests_run++; if (ev_q.size() !== FLEN) begin fails++; $display("FAIL flush_count: got %0d strobes expected %0d", ev_q.size(), FLEN); end
    else begin
      for (int i = 0; i < FLEN; i++) begin
        tests_run++;
        if (ev_q[i].coef !== 1'b0 || ev_q[i].val !== 8'h00 || ev_q[i].cyc !== ev_q[0].cyc + i || ev_q[i].rdy !== 1'b0) begin
          fails++;
          $display("FAIL flush_zero[%0d]: got coef=%b x_n=%02h cyc=%0d rdy=%b expected coef=0 x_n=00 cyc=%0d rdy=0",
                   i, ev_q[i].coef, ev_q[i].val, ev_q[i].cyc, ev_q[i].rdy, ev_q[0].cyc + i);
        end
      end
      tests_run++; if (done_q.size() !== 1 || done_q[0] !== ev_q[FLEN-1].cyc + GAPC) begin
        fails++;
        $display("FAIL flush_done: got %0d pulses first at %0d expected 1 at %0d", done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, ev_q[FLEN-1].cyc + GAPC);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [XW-1:0] nb[TAPS] = '{8'hA1, 8'hB2, 8'hC3};
    int acc;
    int n;
    bit found;
    clear_logs();
    send_byte(8'h40, 0, acc);
    send_byte(8'h11, 0, acc);
    send_byte(8'h22, 0, acc);
    send_byte(8'h33, 0, acc);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (s_set_coeffs && ev_q.size() == 1) found = 1'b1;
      else wait_cycles(1);
    end
    tests_run++; if (!found) begin fails++; $display("FAIL abort_find_burst: second coefficient cycle not seen"); end
    reset = 1'b1;
    wait_cycles(1);
    tests_run++; if (s_set_coeffs !== 1'b0 || s_axis_fir_tvalid !== 1'b0) begin
      fails++; $display("FAIL abort_strobes: got set=%b tvalid=%b expected 0 0", s_set_coeffs, s_axis_fir_tvalid);
    end
    tests_run++; if (in_ready !== 1'b0 || busy !== 1'b1 || x_n !== 8'h00) begin
      fails++; $display("FAIL abort_regs: got in_ready=%b busy=%b x_n=%02h expected 0 1 00", in_ready, busy, x_n);
    end
    reset = 1'b0;
    wait_ready(n);
    tests_run++; if (n !== SETUP) begin fails++; $display("FAIL abort_holdoff: in_ready after %0d cycles expected %0d", n, SETUP); end
    clear_logs();
    send_byte(8'h40, 0, acc);
    for (int i = 0; i < TAPS; i++) send_byte(nb[i], 0, acc);
    wait_cycles(8);
    tests_run++; if (ev_q.size() !== TAPS) begin fails++; $display("FAIL abort_reload_count: got %0d expected %0d", ev_q.size(), TAPS); end
    else begin
      for (int i = 0; i < TAPS; i++) begin
        tests_run++;
        if (ev_q[i].coef !== 1'b1 || ev_q[i].val !== nb[i]) begin
          fails++; $display("FAIL abort_reload[%0d]: got coef=%b x_n=%02h expected coef=1 x_n=%02h", i, ev_q[i].coef, ev_q[i].val, nb[i]);
        end
      end
    end
  endtask

  // Random command mix; expected FIR events follow from the command list alone
  task automatic test_random();
    logic [XW-1:0] exp_v[$];
    bit            exp_c[$];
    int            exp_g[$];
    int            exp_k[$];
    int ncmd;
    int acc;
    int op;
    int arg;
    int gap;
    int n;
    int bad;
    logic [XW-1:0] b;
    clear_logs();
    ncmd = 0;
    for (int c = 0; c < 1000 && !timed_out; c++) begin
      op  = $urandom_range(0, 3);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      case (op)
        0: send_byte({2'b00, 6'($urandom)}, gap, acc);
        1: begin
          send_byte({2'b01, 6'($urandom)}, gap, acc);
          for (int i = 0; i < TAPS; i++) begin
            b = 8'($urandom);
            send_byte(b, ($urandom_range(0, 3) == 0) ? 1 : 0, acc);
            exp_v.push_back(b); exp_c.push_back(1'b1); exp_g.push_back(c); exp_k.push_back(0);
          end
        end
        2: begin
          arg = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
          send_byte({2'b10, 6'(arg)}, gap, acc);
          for (int i = 0; i <= arg; i++) begin
            b = 8'($urandom);
            send_byte(b, ($urandom_range(0, 3) == 0) ? 1 : 0, acc);
            exp_v.push_back(b); exp_c.push_back(1'b0); exp_g.push_back(c); exp_k.push_back(1);
          end
        end
        default: begin
          send_byte({2'b11, 6'($urandom)}, gap, acc);
          for (int i = 0; i < FLEN; i++) begin
            exp_v.push_back(8'h00); exp_c.push_back(1'b0); exp_g.push_back(c); exp_k.push_back(2);
          end
        end
      endcase
      ncmd++;
    end
    wait_cycles(30);
    tests_run++; if (ev_q.size() !== exp_v.size()) begin fails++; $display("FAIL rand_event_count: got %0d expected %0d", ev_q.size(), exp_v.size()); end
    n = (ev_q.size() < exp_v.size()) ? ev_q.size() : exp_v.size();
    bad = -1;
    for (int i = 0; i < n && bad < 0; i++) begin
      if (ev_q[i].coef !== exp_c[i] || ev_q[i].val !== exp_v[i]) bad = i;
    end
    tests_run++; if (bad >= 0) begin
      fails++; $display("FAIL rand_payload[%0d]: got coef=%b x_n=%02h expected coef=%b x_n=%02h", bad, ev_q[bad].coef, ev_q[bad].val, exp_c[bad], exp_v[bad]);
    end
    bad = -1;
    for (int i = 0; i + 1 < n && bad < 0; i++) begin
      if (exp_g[i] == exp_g[i+1] && exp_k[i] != 1 && ev_q[i+1].cyc != ev_q[i].cyc + 1) bad = i;
    end
    tests_run++; if (bad >= 0) begin
      fails++; $display("FAIL rand_burst_hole[%0d]: strobes at %0d and %0d expected adjacent", bad, ev_q[bad].cyc, ev_q[bad+1].cyc);
    end
    bad = -1;
    for (int i = 0; i + 1 < n && bad < 0; i++) begin
      if (exp_g[i] != exp_g[i+1] && ev_q[i+1].cyc < ev_q[i].cyc + GAPC + 1) bad = i;
    end
    tests_run++; if (bad >= 0) begin
      fails++; $display("FAIL rand_gap[%0d]: next burst at %0d after %0d expected at least %0d", bad, ev_q[bad+1].cyc, ev_q[bad].cyc, ev_q[bad].cyc + GAPC + 1);
    end
    tests_run++; if (both_cnt !== 0) begin fails++; $display("FAIL rand_exclusive: got %0d cycles with both strobes expected 0", both_cnt); end
    tests_run++; if (done_q.size() !== ncmd) begin fails++; $display("FAIL rand_done_count: got %0d expected %0d", done_q.size(), ncmd); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
